// File: rtl/piezo_arbiter.sv
// Fixed-priority (0>1>2) owner arbiter for the single piezo_ctrl, enforcing a minimum
// note hold time and a silent gap on every owner change so the piezo never chops.
module piezo_arbiter #(
  parameter int PITCH_W  = 32,
  parameter int MIN_HOLD = 30,
  parameter int GAP      = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_tick,
  input  logic               i_mute,
  input  logic [2:0]         i_req_en,
  input  logic [PITCH_W-1:0] i_pitch0,
  input  logic [PITCH_W-1:0] i_pitch1,
  input  logic [PITCH_W-1:0] i_pitch2,
  output logic               o_play_en,
  output logic [PITCH_W-1:0] o_cnt_limit,
  output logic [2:0]         o_grant,
  output logic               o_busy
);

  localparam int HOLD_W = (MIN_HOLD < 1) ? 1 : $clog2(MIN_HOLD + 1);
  localparam int GAP_W  = (GAP < 1) ? 1 : $clog2(GAP + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MIN_HOLD);
  localparam logic [GAP_W-1:0]  GAP_MAX  = GAP_W'(GAP);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          grant_q, grant_d;
  logic [PITCH_W-1:0]  limit_q, limit_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic                play_q, play_d;
  logic                busy_q, busy_d;

  logic [2:0]          valid;
  logic [2:0]          win;
  logic [PITCH_W-1:0]  win_pitch;
  logic [PITCH_W-1:0]  owner_pitch;
  logic                owner_valid;
  logic                higher_valid;
  logic                hold_done;
  logic                gap_done;

  // A zero pitch would make piezo_ctrl divide by zero, so it never counts as a request.
  assign valid[0] = i_req_en[0] && (i_pitch0 != '0);
  assign valid[1] = i_req_en[1] && (i_pitch1 != '0);
  assign valid[2] = i_req_en[2] && (i_pitch2 != '0);

  // Lowest set bit of valid is the highest-priority requester.
  assign win = valid & (~valid + 3'd1);

  always_comb begin
    win_pitch = '0;
    unique case (win)
      3'b001:  win_pitch = i_pitch0;
      3'b010:  win_pitch = i_pitch1;
      3'b100:  win_pitch = i_pitch2;
      default: win_pitch = '0;
    endcase
  end

  always_comb begin
    owner_pitch = '0;
    unique case (grant_q)
      3'b001:  owner_pitch = i_pitch0;
      3'b010:  owner_pitch = i_pitch1;
      3'b100:  owner_pitch = i_pitch2;
      default: owner_pitch = '0;
    endcase
  end

  // grant_q - 1 masks exactly the indices that outrank the current one-hot owner.
  assign owner_valid  = |(valid & grant_q);
  assign higher_valid = |(valid & (grant_q - 3'd1));
  assign hold_done    = (hold_q == HOLD_MAX);
  assign gap_done     = (gap_q == GAP_MAX);

  // NOTE: combinational blocks use blocking assignments and give every output a default
  // first, so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    limit_d = limit_q;
    hold_d  = hold_q;
    gap_d   = gap_q;

    if (i_mute) begin
      state_d = S_IDLE;
      grant_d = '0;
      limit_d = '0;
      hold_d  = '0;
      gap_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (|valid) begin
            state_d = S_PLAY;
            grant_d = win;
            limit_d = win_pitch;
            hold_d  = '0;
          end
        end

        S_PLAY: begin
          if (hold_done && (!owner_valid || higher_valid)) begin
            state_d = S_GAP;
            grant_d = '0;
            limit_d = '0;
            gap_d   = '0;
          end else begin
            // A vanished owner keeps its last non-zero pitch until the hold time expires.
            if (owner_valid) limit_d = owner_pitch;
            if (i_tick && !hold_done) hold_d = hold_q + HOLD_W'(1);
          end
        end

        S_GAP: begin
          if (gap_done) begin
            if (|valid) begin
              state_d = S_PLAY;
              grant_d = win;
              limit_d = win_pitch;
              hold_d  = '0;
            end else begin
              state_d = S_IDLE;
            end
          end else if (i_tick) begin
            gap_d = gap_q + GAP_W'(1);
          end
        end

        default: begin
          state_d = S_IDLE;
          grant_d = '0;
          limit_d = '0;
          hold_d  = '0;
          gap_d   = '0;
        end
      endcase
    end

    play_d = (state_d == S_PLAY);
    busy_d = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      limit_q <= '0;
      hold_q  <= '0;
      gap_q   <= '0;
      play_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      limit_q <= limit_d;
      hold_q  <= hold_d;
      gap_q   <= gap_d;
      play_q  <= play_d;
      busy_q  <= busy_d;
    end
  end

  assign o_play_en   = play_q;
  assign o_cnt_limit = limit_q;
  assign o_grant     = grant_q;
  assign o_busy      = busy_q;

endmodule

// File: tb/tb_piezo_arbiter.sv
// Self-checking bench for piezo_arbiter: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against an owner/timer model.
module tb_piezo_arbiter;

  localparam int PITCH_W  = 32;
  localparam int MIN_HOLD = 30;
  localparam int GAP      = 5;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               tick;
  logic               mute;
  logic [2:0]         req_en;
  logic [PITCH_W-1:0] pitch [3];
  logic               play_en;
  logic [PITCH_W-1:0] cnt_limit;
  logic [2:0]         grant;
  logic               busy;

  piezo_arbiter #(.PITCH_W(PITCH_W), .MIN_HOLD(MIN_HOLD), .GAP(GAP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_tick     (tick),
    .i_mute     (mute),
    .i_req_en   (req_en),
    .i_pitch0   (pitch[0]),
    .i_pitch1   (pitch[1]),
    .i_pitch2   (pitch[2]),
    .o_play_en  (play_en),
    .o_cnt_limit(cnt_limit),
    .o_grant    (grant),
    .o_busy     (busy)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;
  bit tick_rand = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
  endtask

  // Reference model: who owns the piezo, how many ticks it has owned it, whether we are
  // in the silent gap and for how many ticks, and which pitch is being played.
  int          m_owner;
  bit          m_in_gap;
  int          m_held;
  int          m_gap_ticks;
  logic [31:0] m_out;
  bit          mv [3];
  int          mw;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner = -1; m_in_gap = 0; m_held = 0; m_gap_ticks = 0; m_out = 0;
    end else begin
      mw = -1;
      for (int i = 2; i >= 0; i--) begin
        mv[i] = req_en[i] && (pitch[i] != 0);
        if (mv[i]) mw = i;
      end
      if (mute) begin
        m_owner = -1; m_in_gap = 0; m_out = 0;
      end else if (m_owner >= 0) begin
        if (m_held >= MIN_HOLD && (!mv[m_owner] || (mw >= 0 && mw < m_owner))) begin
          m_owner = -1; m_in_gap = 1; m_gap_ticks = 0; m_out = 0;
        end else begin
          if (mv[m_owner]) m_out = pitch[m_owner];
          if (tick && m_held < MIN_HOLD) m_held++;
        end
      end else if (m_in_gap) begin
        if (m_gap_ticks >= GAP) begin
          m_in_gap = 0;
          if (mw >= 0) begin m_owner = mw; m_held = 0; m_out = pitch[mw]; end
        end else if (tick) m_gap_ticks++;
      end else if (mw >= 0) begin
        m_owner = mw; m_held = 0; m_out = pitch[mw];
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en && rst_n) begin
      check("model_play_en",   32'(play_en), (m_owner >= 0) ? 32'd1 : 32'd0);
      check("model_cnt_limit", cnt_limit, m_out);
      check("model_grant",     32'(grant), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
      check("model_busy",      32'(busy), (m_owner >= 0 || m_in_gap) ? 32'd1 : 32'd0);
    end
  end

  always @(negedge clk) tick = tick_rand ? ($urandom_range(0, 2) == 0) : 1'b1;

  task automatic count_while(input logic [2:0] g, output int n);
    n = 0;
    while (grant == g && busy && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin n++; @(negedge clk); end
    check("wait_idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic check_outs(input string name, input logic pe, input logic [31:0] cl,
                            input logic [2:0] g, input logic b);
    check({name, "_play_en"},   32'(play_en), 32'(pe));
    check({name, "_cnt_limit"}, cnt_limit, cl);
    check({name, "_grant"},     32'(grant), 32'(g));
    check({name, "_busy"},      32'(busy), 32'(b));
  endtask

  int n;

  initial begin
    rst_n = 1'b0; mute = 1'b0; req_en = '0; tick = 1'b0;
    for (int i = 0; i < 3; i++) pitch[i] = '0;
    #35;
    check_outs("reset", 1'b0, 0, 3'b000, 1'b0);
    @(negedge clk); rst_n = 1'b1; cmp_en = 1'b1;
    @(negedge clk);

    // Scenario 1/2: req2 plays, req0 arrives at hold=10 and waits for the hold plus gap.
    pitch[2] = 1000; req_en = 3'b100;
    @(negedge clk);
    check_outs("t1", 1'b1, 1000, 3'b100, 1'b1);
    repeat (10) @(negedge clk);
    pitch[0] = 500; req_en = 3'b101;
    @(negedge clk);
    count_while(3'b100, n);
    check("t2_remaining_hold_cycles", n, 20);
    count_while(3'b000, n);
    check("t2_gap_cycles", n, GAP + 1);
    check_outs("t2_new_owner", 1'b1, 500, 3'b001, 1'b1);
    req_en = 3'b000;
    wait_idle();

    // Scenario 3: short req0 pulse is stretched to the minimum hold, then gap, then idle.
    pitch[0] = 700; req_en = 3'b001;
    repeat (3) @(negedge clk);
    req_en = 3'b000;
    @(negedge clk);
    check_outs("t3_stretch", 1'b1, 700, 3'b001, 1'b1);
    count_while(3'b001, n);
    check("t3_stretch_cycles", n, MIN_HOLD - 2);
    count_while(3'b000, n);
    check("t3_gap_cycles", n, GAP + 1);
    check_outs("t3_idle", 1'b0, 0, 3'b000, 1'b0);

    // Scenario 4: enabled requester with zero pitch is ignored until the pitch is set.
    pitch[1] = 0; req_en = 3'b010;
    repeat (4) @(negedge clk);
    check_outs("t4_zero_pitch", 1'b0, 0, 3'b000, 1'b0);
    pitch[1] = 900;
    @(negedge clk);
    check_outs("t4_grant", 1'b1, 900, 3'b010, 1'b1);

    // Scenario 6a: mute kills the grant at once; release re-arbitrates with no gap.
    repeat (3) @(negedge clk);
    mute = 1'b1;
    @(negedge clk);
    check_outs("t6_mute", 1'b0, 0, 3'b000, 1'b0);
    repeat (3) @(negedge clk);
    check_outs("t6_mute_held", 1'b0, 0, 3'b000, 1'b0);
    mute = 1'b0;
    @(negedge clk);
    check_outs("t6_unmute", 1'b1, 900, 3'b010, 1'b1);
    req_en = 3'b000;
    wait_idle();

    // Scenario 5: pitch change mid-play follows with one clock of lag, no gap.
    pitch[0] = 1000; req_en = 3'b001;
    @(negedge clk);
    check("t5_before", cnt_limit, 1000);
    repeat (2) @(negedge clk);
    pitch[0] = 800;
    @(negedge clk);
    check_outs("t5_after", 1'b1, 800, 3'b001, 1'b1);

    // Scenario 6b: reset asserted in the middle of the gap clears everything immediately.
    req_en = 3'b000;
    n = 0;
    while (!(busy && !play_en) && n < 200) begin n++; @(negedge clk); end
    check("t6_reached_gap", 32'(busy && !play_en), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_outs("t6_reset_gap", 1'b0, 0, 3'b000, 1'b0);
    @(negedge clk); rst_n = 1'b1;

    // Randomized traffic, compared every cycle against the model.
    tick_rand = 1'b1;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(0, 59) == 0) req_en[i] = ~req_en[i];
        if ($urandom_range(0, 99) == 0)
          pitch[i] = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom_range(1, 5000));
      end
      if (mute) mute = ($urandom_range(0, 9) != 0);
      else      mute = ($urandom_range(0, 499) == 0);
    end

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
